// File: rtl/exec_pkg.sv
// Shared types and default widths for the execute/writeback stage.
`timescale 1ns/1ps
package exec_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MOV = 4'd7,
        OP_MUL = 4'd8,
        OP_NOP = 4'd15
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;
endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: W x W -> 2W, one partial product per cycle.
// product/done are combinational views of the step being taken this cycle,
// so the caller can capture the final product on the same edge the last
// step completes.
`timescale 1ns/1ps
module mul_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [2*W-1:0] mcand_reg;
    logic [2*W-1:0] acc_reg;
    logic [W-1:0]   mplier_reg;
    logic [CW-1:0]  step_reg;
    logic           busy_reg;
    logic [2*W-1:0] partial;

    assign partial = mplier_reg[0] ? mcand_reg : '0;
    assign product = acc_reg + partial;
    assign done    = busy_reg && (step_reg == LAST);

    // Load operands on start, then add one shifted multiplicand per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            step_reg   <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{W{1'b0}}, a};
            acc_reg    <= '0;
            mplier_reg <= b;
            step_reg   <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= product;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            step_reg   <= step_reg + 1'b1;
            if (step_reg == LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/exec_wb_stage.sv
// Execute + writeback stage: ALU/MUL, result forwarding, regfile write port.
`timescale 1ns/1ps
module exec_wb_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic              w_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              flag_z,
    output logic              flag_c
);
    localparam int CW  = $clog2(DATA_W);
    localparam int SHW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    state_t              state_reg;
    logic [CW-1:0]       cnt_reg;
    logic [ADDR_W-1:0]   mul_rd_reg;
    logic                w_en_reg;
    logic [ADDR_W-1:0]   write_addr_reg;
    logic [DATA_W-1:0]   write_data_reg;
    logic                flag_z_reg;
    logic                flag_c_reg;

    logic                accept;
    logic                is_mul;
    logic                fwd_rs1;
    logic                fwd_rs2;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_wr;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign in_ready   = (state_reg == S_IDLE);
    assign accept     = in_valid && in_ready;
    assign is_mul     = (in_op == OP_MUL);
    assign w_en       = w_en_reg;
    assign write_addr = write_addr_reg;
    assign write_data = write_data_reg;
    assign flag_z     = flag_z_reg;
    assign flag_c     = flag_c_reg;

    // The regfile only commits at the end of the w_en cycle, so bypass it.
    assign fwd_rs1 = w_en_reg && (write_addr_reg != '0) && (in_rs1 == write_addr_reg);
    assign fwd_rs2 = !in_use_imm && w_en_reg && (write_addr_reg != '0) && (in_rs2 == write_addr_reg);
    assign opa     = fwd_rs1 ? write_data_reg : in_a;
    assign opb     = in_use_imm ? in_imm : (fwd_rs2 ? write_data_reg : in_b);

    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = {1'b0, opa} - {1'b0, opb};

    // Single-cycle ALU; MUL and NOP produce no direct write.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        case (op_t'(in_op))
            OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
            OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_XOR: alu_res = opa ^ opb;
            OP_SHL: alu_res = opa << opb[SHW-1:0];
            OP_SHR: alu_res = opa >> opb[SHW-1:0];
            OP_MOV: alu_res = opb;
            default: alu_wr = 1'b0;
        endcase
    end

    mul_iter #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_product)
    );

    // Control FSM and writeback register; w_en is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            mul_rd_reg     <= '0;
            w_en_reg       <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
            flag_z_reg     <= 1'b0;
            flag_c_reg     <= 1'b0;
        end else begin
            w_en_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_reg  <= S_MUL;
                            cnt_reg    <= '0;
                            mul_rd_reg <= in_rd;
                        end else if (alu_wr && (in_rd != '0)) begin
                            w_en_reg       <= 1'b1;
                            write_addr_reg <= in_rd;
                            write_data_reg <= alu_res;
                            flag_z_reg     <= (alu_res == '0);
                            flag_c_reg     <= alu_c;
                        end
                    end
                end
                S_MUL: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if ((cnt_reg == LAST) && mul_done) begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                        if (mul_rd_reg != '0) begin
                            w_en_reg       <= 1'b1;
                            write_addr_reg <= mul_rd_reg;
                            write_data_reg <= mul_product[DATA_W-1:0];
                            flag_z_reg     <= (mul_product[DATA_W-1:0] == '0);
                            flag_c_reg     <= |mul_product[2*DATA_W-1:DATA_W];
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_wb_stage.sv
// Scoreboard bench for exec_wb_stage: driver issues ops against an
// architectural register model, monitor checks every cycle.
`timescale 1ns/1ps
module tb_exec_wb_stage;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_use_imm;
    logic [DW-1:0] in_imm;
    logic          w_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          flag_z;
    logic          flag_c;

    exec_wb_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .w_en       (w_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical regfile fed by the DUT write port; reads are stale by design.
    logic [DW-1:0] hw_rf [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (w_en && write_addr != 0) hw_rf[write_addr] <= write_data;
    end
    always_comb begin
        in_a = (in_rs1 == 0) ? 8'h00 : hw_rf[in_rs1];
        in_b = (in_rs2 == 0) ? 8'h00 : hw_rf[in_rs2];
    end

    typedef struct {
        int cyc;
        int addr;
        int data;
        int z;
        int c;
    } wr_t;

    wr_t sbq[$];
    int  arch [8] = '{default: 0};
    int  mul_acc_cyc = -100;
    int  n_checks = 0;
    int  n_fail = 0;
    int  exp_z = 0;
    int  exp_c = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: architectural semantics of each opcode in plain integers.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output int c, output bit writes);
        writes = 1'b1;
        c = 0;
        res = 0;
        case (op)
            0: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (a << (b % 8)) % 256;
            6: res = a >> (b % 8);
            7: res = b;
            8: begin res = (a * b) % 256; c = (a * b > 255) ? 1 : 0; end
            default: writes = 1'b0;
        endcase
    endfunction

    task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                         input bit use_imm, input int imm);
        int  a, b, res, c;
        bit  wr;
        bit  taken;
        wr_t e;
        in_valid   = 1'b1;
        in_op      = op[3:0];
        in_rd      = rd[AW-1:0];
        in_rs1     = rs1[AW-1:0];
        in_rs2     = rs2[AW-1:0];
        in_use_imm = use_imm;
        in_imm     = imm[DW-1:0];
        taken      = 1'b0;
        for (int w = 0; w < 40 && !taken; w++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                a = arch[rs1];
                b = use_imm ? imm : arch[rs2];
                ref_alu(op, a, b, res, c, wr);
                if (op == 8) mul_acc_cyc = cyc;
                if (wr && rd != 0) begin
                    arch[rd] = res;
                    e.cyc  = cyc + ((op == 8) ? DW + 1 : 1);
                    e.addr = rd;
                    e.data = res;
                    e.z    = (res == 0) ? 1 : 0;
                    e.c    = c;
                    sbq.push_back(e);
                end
                $display("issue cyc=%0d op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0d/0x%0h a=0x%0h b=0x%0h",
                         cyc, op, rd, rs1, rs2, use_imm, imm, a, b);
            end
            @(posedge clk);
            #1;
        end
        if (!taken) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Monitor: compares every cycle against the scoreboard and flag model.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq.delete();
                exp_z = 0;
                exp_c = 0;
            end else begin
                chk("in_ready", int'(in_ready),
                    (cyc > mul_acc_cyc && cyc <= mul_acc_cyc + DW) ? 0 : 1);
                if (w_en) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_w_en", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("wb_cycle", cyc, e.cyc);
                        chk("write_addr", int'(write_addr), e.addr);
                        chk("write_data", int'(write_data), e.data);
                        exp_z = e.z;
                        exp_c = e.c;
                        $display("write cyc=%0d r%0d=0x%0h z=%0d c=%0d", cyc, write_addr, write_data, flag_z, flag_c);
                    end
                end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    chk("missing_w_en", 0, 1);
                    void'(sbq.pop_front());
                end
                chk("flag_z", int'(flag_z), exp_z);
                chk("flag_c", int'(flag_c), exp_c);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        int saved;
        int op;
        in_valid = 1'b0; in_op = 4'd0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_imm = 1'b0; in_imm = '0;

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_w_en", int'(w_en), 0);
        chk("rst_write_addr", int'(write_addr), 0);
        chk("rst_write_data", int'(write_data), 0);
        chk("rst_flag_z", int'(flag_z), 0);
        chk("rst_flag_c", int'(flag_c), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(in_ready), 1);
        @(posedge clk); #1;

        // ADD with carry out
        issue(7, 6, 0, 0, 1, 'hF0);
        issue(0, 1, 6, 0, 1, 'h20);
        // Back-to-back forwarding on both sources
        issue(7, 2, 0, 0, 1, 'h05);
        issue(0, 3, 2, 2, 0, 0);
        // MUL with overflow, next op held during busy and forwarded from MUL
        issue(7, 1, 0, 0, 1, 'h12);
        issue(7, 7, 0, 0, 1, 'h10);
        issue(8, 4, 1, 7, 0, 0);
        issue(0, 5, 4, 4, 0, 0);
        // rd=0 write suppression, then borrow
        issue(7, 1, 0, 0, 1, 1);
        issue(7, 2, 0, 0, 1, 2);
        issue(1, 0, 1, 2, 0, 0);
        issue(1, 5, 1, 2, 0, 0);

        // Reset in the middle of a MUL abandons it
        issue(7, 3, 0, 0, 1, 7);
        saved = arch[6];
        issue(8, 6, 3, 3, 0, 0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        arch[6] = saved;
        mul_acc_cyc = -100;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mul_abort", int'(in_ready), 1);
        chk("w_en_after_mul_abort", int'(w_en), 0);
        @(posedge clk); #1;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 15);
            if (op == 8 && $urandom_range(0, 2) != 0) op = $urandom_range(0, 7);
            issue(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), $urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end

        // Drain outstanding writes
        for (int w = 0; w < 20 && sbq.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
